// File: rtl/demux_sched_pkg.sv
// Shared types, limits and round-robin helper for demux_rr_scheduler.
package demux_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SEND,
    ST_GAP
  } sched_state_t;

  typedef logic [1:0] chan_t;

  localparam int unsigned BURST_MAX = 16;
  localparam int unsigned GAP_MAX   = 7;
  localparam int unsigned CNT_W     = $clog2(BURST_MAX + 1);
  localparam int unsigned GCNT_W    = $clog2(GAP_MAX + 1);

  // First channel set in mask strictly after last, wrapping 3->0; last if mask is empty.
  function automatic chan_t rr_next(chan_t last, logic [3:0] mask);
    chan_t pick;
    chan_t idx;
    logic  found;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = chan_t'(32'(last) + i);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/demux_1x4.sv
// Combinational 1x4 demultiplexer: routes y to the output chosen by {S_1,S_0}.
module demux_1x4 (
  input  logic y,
  input  logic S_0,
  input  logic S_1,
  output logic a,
  output logic b,
  output logic c,
  output logic d
);

  // Steer y to exactly one output; the others stay low.
  always_comb begin
    a = 1'b0;
    b = 1'b0;
    c = 1'b0;
    d = 1'b0;
    case ({S_1, S_0})
      2'd0:    a = y;
      2'd1:    b = y;
      2'd2:    c = y;
      default: d = y;
    endcase
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin burst scheduler sharing one serial stream across four sinks
// through demux_1x4. Optional macro DEMUX_SCHED_SKIP_EN: selection also
// requires dst_ready, so a stalled sink loses its turn.
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int unsigned BURST = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] en,
  input  logic       y,
  input  logic       y_valid,
  output logic       y_ready,
  input  logic [3:0] dst_ready,
  output logic       S_0,
  output logic       S_1,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] dst_valid,
  output logic       busy
);

  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST - 1);
  localparam logic [GCNT_W-1:0] GAP_LAST   = GCNT_W'((GAP == 0) ? 0 : GAP - 1);

  sched_state_t      state_q, state_d;
  chan_t             sel_q, last_q, next_ch;
  logic [CNT_W-1:0]  cnt_q;
  logic [GCNT_W-1:0] gcnt_q;
  logic [3:0]        elig;
  logic              xfer;
  logic              y_gated;
  logic              dm_a, dm_b, dm_c, dm_d;

`ifdef DEMUX_SCHED_SKIP_EN
  assign elig = en & dst_ready;
`else
  assign elig = en;
`endif

  assign next_ch = rr_next(last_q, elig);
  assign S_0     = sel_q[0];
  assign S_1     = sel_q[1];
  assign busy    = (state_q != ST_IDLE);
  assign xfer    = y_valid & y_ready;
  assign y_gated = y & xfer;

  // Source handshake: only a granted, enabled and ready sink accepts data.
  always_comb begin
    y_ready = 1'b0;
    if (state_q == ST_SEND) y_ready = dst_ready[sel_q] & en[sel_q];
  end

  // Next-state logic; an abort (en[sel] low) ends the burst like a completed one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|elig) state_d = ST_SELECT;
      ST_SELECT: state_d = (|elig) ? ST_SEND : ST_IDLE;
      ST_SEND: begin
        if (!en[sel_q] || (xfer && cnt_q == BURST_LAST))
          state_d = (GAP == 0) ? ST_SELECT : ST_GAP;
      end
      ST_GAP:    if (gcnt_q == GAP_LAST) state_d = (|elig) ? ST_SELECT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, grant and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_SELECT: begin
          if (|elig) begin
            sel_q  <= next_ch;
            last_q <= next_ch;
            cnt_q  <= '0;
          end
        end
        ST_SEND: begin
          if (xfer) cnt_q <= cnt_q + 1'b1;
          if (state_d == ST_GAP) gcnt_q <= '0;
        end
        ST_GAP:  gcnt_q <= gcnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  demux_1x4 u_demux (
    .y   (y_gated),
    .S_0 (S_0),
    .S_1 (S_1),
    .a   (dm_a),
    .b   (dm_b),
    .c   (dm_c),
    .d   (dm_d)
  );

  // Register the demux outputs and the one-hot strobe of the transferred bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      {a, b, c, d} <= '0;
      dst_valid    <= '0;
    end else begin
      {a, b, c, d} <= {dm_a, dm_b, dm_c, dm_d};
      dst_valid    <= xfer ? (4'b0001 << sel_q) : 4'b0000;
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Scoreboard bench for demux_rr_scheduler against a behavioural model.
module tb_demux_rr_scheduler;

  localparam int BURST = 4;
  localparam int GAP   = 1;

  logic       clk = 1'b0;
  logic       rst, y, y_valid, y_ready, S_0, S_1, a, b, c, d, busy;
  logic [3:0] en, dst_ready, dst_valid;

  always #5 clk = ~clk;

  demux_rr_scheduler #(.BURST(BURST), .GAP(GAP)) u_dut (
    .clk(clk), .rst(rst), .en(en), .y(y), .y_valid(y_valid), .y_ready(y_ready),
    .dst_ready(dst_ready), .S_0(S_0), .S_1(S_1), .a(a), .b(b), .c(c), .d(d),
    .dst_valid(dst_valid), .busy(busy)
  );

  typedef struct {
    int cyc;
    int ch;
    bit val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   chk_on = 1'b0;

  // Model: grant >= 0 means a burst is in progress on that channel.
  int m_grant, m_sent, m_gap_left, m_last, m_sel;
  bit m_selecting;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int rr(input int last, input logic [3:0] mask);
    for (int i = 1; i <= 4; i++) begin
      if (mask[(last + i) % 4]) return (last + i) % 4;
    end
    return last;
  endfunction

  task automatic model_reset();
    m_grant = -1; m_sent = 0; m_gap_left = 0; m_selecting = 1'b0; m_last = 3; m_sel = 0;
  endtask

  task automatic end_burst();
    m_grant = -1;
    if (GAP > 0) m_gap_left = GAP;
    else m_selecting = 1'b1;
  endtask

  // One clock cycle: check combinational outputs, advance the model, cross the edge.
  task automatic step();
    logic [3:0] e;
    bit exp_yr, exp_busy;
    #1;
`ifdef DEMUX_SCHED_SKIP_EN
    e = en & dst_ready;
`else
    e = en;
`endif
    exp_yr   = (m_grant >= 0) ? (dst_ready[m_grant] & en[m_grant]) : 1'b0;
    exp_busy = m_selecting || (m_grant >= 0) || (m_gap_left > 0);
    if (chk_on) begin
      check("y_ready", y_ready, exp_yr);
      check("busy", busy, exp_busy);
      check("sel", {S_1, S_0}, m_sel);
    end
    if (rst) model_reset();
    else if (m_selecting) begin
      m_selecting = 1'b0;
      if (e != 0) begin
        m_grant = rr(m_last, e); m_last = m_grant; m_sel = m_grant; m_sent = 0;
      end
    end else if (m_grant >= 0) begin
      if (!en[m_grant]) end_burst();
      else if (y_valid && exp_yr) begin
        q.push_back('{cyc + 1, m_grant, y});
        m_sent++;
        if (m_sent == BURST) end_burst();
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
      if (m_gap_left == 0) m_selecting = (e != 0);
    end else if (e != 0) m_selecting = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: compare every strobe against the scoreboard queue.
  initial begin
    exp_t       ex;
    logic [3:0] outs;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        outs = {d, c, b, a};
        if (dst_valid != 4'b0000) begin
          if (q.size() == 0) begin
            check("strobe_unexpected", dst_valid, 0);
          end else begin
            ex = q.pop_front();
            check("strobe_cycle", cyc, ex.cyc);
            check("dst_valid", dst_valid, 4'b0001 << ex.ch);
            check("data", outs, ex.val ? (4'b0001 << ex.ch) : 4'b0000);
          end
        end else begin
          check("idle_outs", outs, 0);
          check("strobe_missing", (q.size() > 0) && (q[0].cyc <= cyc), 0);
          if ((q.size() > 0) && (q[0].cyc <= cyc)) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int  n;
    rst = 1'b1; en = 4'h0; dst_ready = 4'h0; y = 1'b0; y_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step();
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0;

    // Full rotation a, b, c, d, a with all sinks ready.
    en = 4'hF; dst_ready = 4'hF; y_valid = 1'b1; y = 1'b1;
    repeat (30) step();

    // Two enabled channels alternate.
    en = 4'b0101;
    repeat (30) begin
      y = 1'($urandom); y_valid = ($urandom_range(0, 3) != 0);
      step();
    end

    // Sink b not ready: skipped or stalls depending on configuration, then released.
    en = 4'hF; dst_ready = 4'b1101; y_valid = 1'b1;
    repeat (30) begin y = 1'($urandom); step(); end
    dst_ready = 4'hF;
    repeat (20) begin y = 1'($urandom); step(); end

    // Reset after two bits of a burst on c.
    for (n = 0; n < 200 && !(m_grant == 2 && m_sent == 2); n++) begin
      y = 1'($urandom); step();
    end
    check("reach_c_burst", (m_grant == 2 && m_sent == 2), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (12) begin y = 1'($urandom); step(); end

    // Drop en of the granted channel after one bit.
    for (n = 0; n < 200 && !(m_grant >= 0 && m_sent == 1); n++) begin
      y = 1'($urandom); step();
    end
    check("reach_one_bit", (m_grant >= 0 && m_sent == 1), 1);
    en = en & ~(4'b0001 << m_grant);
    repeat (15) begin y = 1'($urandom); step(); end
    en = 4'hF;

    // Randomised traffic, including occasional resets and enable changes.
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) en = 4'($urandom);
      if ($urandom_range(0, 3) == 0) dst_ready = 4'($urandom);
      y_valid = ($urandom_range(0, 4) != 0);
      y = 1'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    rst = 1'b0; en = 4'h0; y_valid = 1'b0;
    repeat (10) step();
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
